sobel_window_gen: RTL and testbench

Parametrised 3x3 neighbourhood generator for the Sobel pipeline: accepts a raster-order pixel stream, holds two previous image lines in internal line buffers, and emits one fully border-handled 3x3 window per image pixel with its centre coordinates. It replaces the separate external line-buffer FIFOs and the fixed 128x128, zero-pad-only window modulator. It adds a valid/ready input handshake, frame framing (`sof`/`eof`), selectable border mode, and an automatic end-of-frame flush so the bottom row is emitted without extra input.

---
 rtl/sobel_pkg.sv | 30 +++
 rtl/sobel_line_buffer.sv | 30 +++
 rtl/sobel_window_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_sobel_window_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and constants for the Sobel window generator.
//   border_e : out-of-image tap policy (zero fill or nearest-edge replicate)
//   state_e  : window generator FSM states
//   W_TL..W_BR : tap positions inside the packed 3x3 window, row-major,
//                W_TL at the least-significant slot.
package sobel_pkg;

  typedef enum logic {
    BORDER_ZERO      = 1'b0,
    BORDER_REPLICATE = 1'b1
  } border_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_e;

  localparam int W_TL = 0;
  localparam int W_TC = 1;
  localparam int W_TR = 2;
  localparam int W_ML = 3;
  localparam int W_MC = 4;
  localparam int W_MR = 5;
  localparam int W_BL = 6;
  localparam int W_BC = 7;
  localparam int W_BR = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: DEPTH-stage shift delay with enable.
//   clk  : clock
//   en   : advance the delay line by one pixel
//   din  : pixel entering the line
//   dout : pixel that entered DEPTH enabled cycles ago
// Contents are not reset; every consumer masks stale data by position.
module sobel_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-order pixel stream in, one border-handled 3x3
// window per image pixel out, tagged with its centre coordinates.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready low during reset and flush)
//   in_data, in_sof     : pixel and first-pixel-of-frame marker
//   out_valid           : single-cycle window strobe (no backpressure)
//   out_win             : taps w0..w8, w0 (top-left) at the LSBs
//   out_row, out_col    : centre coordinates of out_win
//   out_eof             : set with the window centred on (ROWS-1, COLS-1)
//   sof_err             : pulse on a missing or unexpected start of frame
// The window for centre p is produced when pixel p+COLS+1 arrives; after the
// last pixel the block flushes COLS+1 masked dummy pixels on its own.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COLS   = 128,
  parameter int ROWS   = 128,
  parameter int BORDER = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  output logic                     out_valid,
  output logic [9*DATA_W-1:0]      out_win,
  output logic [$clog2(ROWS)-1:0]  out_row,
  output logic [$clog2(COLS)-1:0]  out_col,
  output logic                     out_eof,
  output logic                     sof_err
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int KW = $clog2(ROWS*COLS);
  localparam logic [KW-1:0] K_FILL_END = KW'(COLS + 1);
  localparam logic [KW-1:0] K_LAST     = KW'(ROWS*COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam border_e       BMODE      = (BORDER == 1) ? BORDER_REPLICATE : BORDER_ZERO;

  state_e            state_reg, state_next;
  logic [KW-1:0]     k_reg, k_next;
  logic [RW-1:0]     crow_reg;
  logic [CW-1:0]     ccol_reg;
  logic              accept, flush_cyc, shift_en;
  logic              emit, restart, err, last_centre;
  logic [DATA_W-1:0] pix_in, lb0_out, lb1_out;
  logic [DATA_W-1:0] mid_reg [3];
  logic [DATA_W-1:0] old_reg [3];
  logic [DATA_W-1:0] new_col [3];
  logic [DATA_W-1:0] raw [9];
  logic [9*DATA_W-1:0] win_next;

  assign in_ready    = !rst && (state_reg != ST_FLUSH);
  assign accept      = in_valid && in_ready;
  assign flush_cyc   = (state_reg == ST_FLUSH);
  // A stray pixel in IDLE is dropped and must not enter the line buffers.
  assign shift_en    = (accept && !(state_reg == ST_IDLE && !in_sof)) || flush_cyc;
  assign pix_in      = flush_cyc ? '0 : in_data;
  assign last_centre = (crow_reg == ROW_LAST) && (ccol_reg == COL_LAST);

  sobel_line_buffer #(.DATA_W(DATA_W), .DEPTH(COLS)) u_lb0 (
    .clk  (clk),
    .en   (shift_en),
    .din  (pix_in),
    .dout (lb0_out)
  );

  sobel_line_buffer #(.DATA_W(DATA_W), .DEPTH(COLS)) u_lb1 (
    .clk  (clk),
    .en   (shift_en),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // Newest column: top = k-2*COLS, middle = k-COLS, bottom = k.
  assign new_col[0] = lb1_out;
  assign new_col[1] = lb0_out;
  assign new_col[2] = pix_in;

  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int i = 0; i < 3; i++) begin
        old_reg[i] <= mid_reg[i];
        mid_reg[i] <= new_col[i];
      end
    end
  end

  // Unmasked window as it will look after this cycle's shift.
  assign raw[W_TL] = old_reg[0];
  assign raw[W_TC] = mid_reg[0];
  assign raw[W_TR] = new_col[0];
  assign raw[W_ML] = old_reg[1];
  assign raw[W_MC] = mid_reg[1];
  assign raw[W_MR] = new_col[1];
  assign raw[W_BL] = old_reg[2];
  assign raw[W_BC] = mid_reg[2];
  assign raw[W_BR] = new_col[2];

  // Per-tap border handling. A left/right tap at the image edge physically
  // holds a pixel from the neighbouring line, so the column test also covers
  // wrap. Replicate mode redirects to the clamped position, which always
  // lies in the centre row and/or centre column of the same window.
  for (genvar gi = 0; gi < 9; gi++) begin : g_tap
    localparam int DR    = gi / 3 - 1;
    localparam int DC    = gi % 3 - 1;
    localparam int SRC_R = 3 + gi % 3;
    localparam int SRC_C = (gi / 3) * 3 + 1;

    logic              row_oob, col_oob;
    logic [DATA_W-1:0] tap;

    assign row_oob = (DR < 0) ? (crow_reg == '0) :
                     (DR > 0) ? (crow_reg == ROW_LAST) : 1'b0;
    assign col_oob = (DC < 0) ? (ccol_reg == '0) :
                     (DC > 0) ? (ccol_reg == COL_LAST) : 1'b0;

    always_comb begin
      tap = raw[gi];
      if (row_oob || col_oob) begin
        if (BMODE == BORDER_ZERO) begin
          tap = '0;
        end else if (row_oob && col_oob) begin
          tap = raw[W_MC];
        end else if (row_oob) begin
          tap = raw[SRC_R];
        end else begin
          tap = raw[SRC_C];
        end
      end
    end

    assign win_next[gi*DATA_W +: DATA_W] = tap;
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    emit       = 1'b0;
    restart    = 1'b0;
    err        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (in_sof) begin
            state_next = ST_FILL;
            k_next     = KW'(1);
            restart    = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
      ST_FILL, ST_RUN: begin
        if (accept) begin
          if (in_sof) begin
            // Abandon the current frame; this pixel is k=0 of a new one.
            err        = 1'b1;
            restart    = 1'b1;
            state_next = ST_FILL;
            k_next     = KW'(1);
          end else begin
            k_next = k_reg + 1'b1;
            if (state_reg == ST_FILL) begin
              if (k_reg == K_FILL_END) begin
                emit       = 1'b1;
                state_next = ST_RUN;
              end
            end else begin
              emit = 1'b1;
              if (k_reg == K_LAST) begin
                state_next = ST_FLUSH;
              end
            end
          end
        end
      end
      ST_FLUSH: begin
        emit = 1'b1;
        if (last_centre) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      crow_reg  <= '0;
      ccol_reg  <= '0;
      out_valid <= 1'b0;
      out_win   <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_eof   <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      out_valid <= emit;
      out_eof   <= emit && last_centre;
      sof_err   <= err;
      if (emit) begin
        out_win <= win_next;
        out_row <= crow_reg;
        out_col <= ccol_reg;
      end
      if (restart) begin
        crow_reg <= '0;
        ccol_reg <= '0;
      end else if (emit) begin
        if (ccol_reg == COL_LAST) begin
          ccol_reg <= '0;
          crow_reg <= (crow_reg == ROW_LAST) ? '0 : crow_reg + 1'b1;
        end else begin
          ccol_reg <= ccol_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x3 image. Two instances share the
// input stream: u_zero (zero border) and u_rep (replicate border).
module tb_sobel_window_gen;

  localparam int C = 4;
  localparam int R = 3;

  typedef struct {
    int          cyc;
    int          row;
    int          col;
    logic [71:0] win;
    logic        eof;
  } win_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_data = 8'd0;

  logic        rdy0, ov0, eof0, err0;
  logic [71:0] win0;
  logic [1:0]  row0, col0;
  logic        rdy1, ov1, eof1, err1;
  logic [71:0] win1;
  logic [1:0]  row1, col1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int err_cnt = 0;
  int eof_cnt = 0;
  int viol_cnt = 0;
  bit prev_fire = 1'b0;
  win_t q0[$];
  win_t q1[$];

  sobel_window_gen #(.DATA_W(8), .COLS(C), .ROWS(R), .BORDER(0)) u_zero (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_sof(in_sof), .out_valid(ov0), .out_win(win0),
    .out_row(row0), .out_col(col0), .out_eof(eof0), .sof_err(err0)
  );

  sobel_window_gen #(.DATA_W(8), .COLS(C), .ROWS(R), .BORDER(1)) u_rep (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_sof(in_sof), .out_valid(ov1), .out_win(win1),
    .out_row(row1), .out_col(col1), .out_eof(eof1), .sof_err(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture windows and protocol events away from the active edge.
  always @(negedge clk) begin
    if (ov0) begin
      q0.push_back('{cyc, int'(row0), int'(col0), win0, eof0});
      $display("win cyc=%0d r=%0d c=%0d eof=%0d zero=%h", cyc, row0, col0, eof0, win0);
    end
    if (ov1) begin
      q1.push_back('{cyc, int'(row1), int'(col1), win1, eof1});
      $display("win cyc=%0d r=%0d c=%0d eof=%0d repl=%h", cyc, row1, col1, eof1, win1);
    end
    if (err0) err_cnt++;
    if (eof0) eof_cnt++;
    if (ov0 && !prev_fire) viol_cnt++;
    prev_fire = (in_valid && rdy0) || (!rdy0 && !rst);
  end

  function automatic logic [7:0] exp_tap(int r, int c, int t, int border, int base);
    int rr, cc;
    bit oob;
    rr  = r + t / 3 - 1;
    cc  = c + t % 3 - 1;
    oob = (rr < 0) || (rr >= R) || (cc < 0) || (cc >= C);
    if (oob && border == 0) return 8'd0;
    if (rr < 0) rr = 0;
    if (rr > R - 1) rr = R - 1;
    if (cc < 0) cc = 0;
    if (cc > C - 1) cc = C - 1;
    return 8'(base + rr * C + cc + 1);
  endfunction

  function automatic logic [71:0] exp_win(int r, int c, int border, int base);
    logic [71:0] w;
    w = '0;
    for (int t = 0; t < 9; t++) w[t*8 +: 8] = exp_tap(r, c, t, border, base);
    return w;
  endfunction

  function automatic logic [71:0] pk(int a0, int a1, int a2, int a3, int a4,
                                     int a5, int a6, int a7, int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic clear_capture();
    q0.delete();
    q1.delete();
    err_cnt  = 0;
    eof_cnt  = 0;
    viol_cnt = 0;
  endtask

  // Present one pixel and hold it until accepted; returns the accept cycle.
  task automatic send_pix(input logic [7:0] d, input logic sof, output int acc_cyc);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    acc_cyc  = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy0) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL accept_timeout got=not_ready exp=ready data=%0d", d);
  endtask

  task automatic send_frame(input int base, input bit gappy, output int acc6, output int acc12);
    int a;
    acc6  = -1;
    acc12 = -1;
    for (int k = 0; k < R * C; k++) begin
      if (gappy && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_pix(8'(base + k + 1), (k == 0), a);
      if (k == 5) acc6 = a;
      if (k == R * C - 1) acc12 = a;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ov0); end
    total++; if (win0 !== 72'd0 || win1 !== 72'd0) begin bad++; $display("FAIL rst_win got=%h/%h exp=0", win0, win1); end
    total++; if (row0 !== 2'd0 || col0 !== 2'd0) begin bad++; $display("FAIL rst_rowcol got=%0d,%0d exp=0,0", row0, col0); end
    total++; if (eof0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", eof0, err0); end
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL rst_ready_in_reset got=%b exp=0", rdy0); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b exp=1", rdy0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int a6, a12, z;
    clear_capture();
    send_frame(0, 1'b0, a6, a12);
    z = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rdy0) z++;
      else break;
    end
    total++; if (z != C + 1) begin bad++; $display("FAIL flush_ready_low got=%0d exp=%0d", z, C + 1); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL flush_ready_back got=%b exp=1", rdy0); end
    settle();
    total++; if (q0.size() != 12) begin bad++; $display("FAIL b2b_count got=%0d exp=12", q0.size()); end
    total++; if (eof_cnt != 1) begin bad++; $display("FAIL b2b_eof_count got=%0d exp=1", eof_cnt); end
    if (q0.size() == 12 && q1.size() == 12) begin
      total++; if (q0[0].cyc != a6) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", q0[0].cyc, a6); end
      total++; if (q0[0].win !== pk(0,0,0,0,1,2,0,5,6)) begin bad++; $display("FAIL zero_c00 got=%h exp=%h", q0[0].win, pk(0,0,0,0,1,2,0,5,6)); end
      total++; if (q0[5].win !== pk(1,2,3,5,6,7,9,10,11)) begin bad++; $display("FAIL zero_c11 got=%h exp=%h", q0[5].win, pk(1,2,3,5,6,7,9,10,11)); end
      total++; if (q0[11].win !== pk(7,8,0,11,12,0,0,0,0) || q0[11].eof !== 1'b1 || q0[11].row != 2 || q0[11].col != 3)
        begin bad++; $display("FAIL zero_c23_eof got=%h eof=%b r=%0d c=%0d exp=%h eof=1 r=2 c=3", q0[11].win, q0[11].eof, q0[11].row, q0[11].col, pk(7,8,0,11,12,0,0,0,0)); end
      total++; if (q1[0].win !== pk(1,1,2,1,1,2,5,5,6)) begin bad++; $display("FAIL repl_c00 got=%h exp=%h", q1[0].win, pk(1,1,2,1,1,2,5,5,6)); end
      total++; if (q1[7].win !== pk(3,4,4,7,8,8,11,12,12)) begin bad++; $display("FAIL repl_c13 got=%h exp=%h", q1[7].win, pk(3,4,4,7,8,8,11,12,12)); end
      for (int i = 0; i < 5; i++) begin
        total++; if (q0[7+i].cyc != a12 + 1 + i) begin bad++; $display("FAIL flush_win_cycle idx=%0d got=%0d exp=%0d", 7 + i, q0[7+i].cyc, a12 + 1 + i); end
      end
      for (int p = 0; p < 12; p++) begin
        total++;
        if (q0[p].row != p / C || q0[p].col != p % C || q0[p].win !== exp_win(p / C, p % C, 0, 0) ||
            q1[p].win !== exp_win(p / C, p % C, 1, 0)) begin
          bad++;
          $display("FAIL b2b_window p=%0d got=r%0d c%0d %h/%h exp=r%0d c%0d %h/%h", p, q0[p].row, q0[p].col,
                   q0[p].win, q1[p].win, p / C, p % C, exp_win(p / C, p % C, 0, 0), exp_win(p / C, p % C, 1, 0));
        end
      end
    end
  endtask

  task automatic test_random_gaps();
    int a6, a12;
    clear_capture();
    send_frame(0, 1'b1, a6, a12);
    settle();
    total++; if (q0.size() != 12) begin bad++; $display("FAIL gaps_count got=%0d exp=12", q0.size()); end
    total++; if (viol_cnt != 0) begin bad++; $display("FAIL gaps_spurious_valid got=%0d exp=0", viol_cnt); end
    total++; if (eof_cnt != 1) begin bad++; $display("FAIL gaps_eof_count got=%0d exp=1", eof_cnt); end
    if (q0.size() == 12 && q1.size() == 12) begin
      for (int p = 0; p < 12; p++) begin
        total++;
        if (q0[p].row != p / C || q0[p].col != p % C || q0[p].win !== exp_win(p / C, p % C, 0, 0) ||
            q1[p].win !== exp_win(p / C, p % C, 1, 0)) begin
          bad++;
          $display("FAIL gaps_window p=%0d got=r%0d c%0d %h/%h exp=%h/%h", p, q0[p].row, q0[p].col,
                   q0[p].win, q1[p].win, exp_win(p / C, p % C, 0, 0), exp_win(p / C, p % C, 1, 0));
        end
      end
    end
  endtask

  task automatic test_sof_errors();
    int a, a6, a12;
    clear_capture();
    send_pix(8'd99, 1'b0, a);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (err_cnt != 1) begin bad++; $display("FAIL idle_nosof_err got=%0d exp=1", err_cnt); end
    total++; if (q0.size() != 0) begin bad++; $display("FAIL idle_nosof_output got=%0d exp=0", q0.size()); end

    clear_capture();
    for (int k = 0; k < 7; k++) send_pix(8'(k + 1), (k == 0), a);
    send_frame(20, 1'b0, a6, a12);
    settle();
    total++; if (err_cnt != 1) begin bad++; $display("FAIL run_sof_err got=%0d exp=1", err_cnt); end
    total++; if (eof_cnt != 1) begin bad++; $display("FAIL run_sof_eof_count got=%0d exp=1", eof_cnt); end
    total++; if (q0.size() != 14) begin bad++; $display("FAIL run_sof_count got=%0d exp=14", q0.size()); end
    if (q0.size() == 14) begin
      total++; if (q0[1].eof !== 1'b0 || q0[1].row != 0 || q0[1].col != 1)
        begin bad++; $display("FAIL run_sof_old_tail got=r%0d c%0d eof=%b exp=r0 c1 eof=0", q0[1].row, q0[1].col, q0[1].eof); end
      total++; if (q0[2].row != 0 || q0[2].col != 0 || q0[2].win !== pk(0,0,0,0,21,22,0,25,26))
        begin bad++; $display("FAIL run_sof_new_c00 got=r%0d c%0d %h exp=r0 c0 %h", q0[2].row, q0[2].col, q0[2].win, pk(0,0,0,0,21,22,0,25,26)); end
      for (int p = 0; p < 12; p++) begin
        total++;
        if (q0[p+2].row != p / C || q0[p+2].col != p % C || q0[p+2].win !== exp_win(p / C, p % C, 0, 20)) begin
          bad++;
          $display("FAIL run_sof_window p=%0d got=r%0d c%0d %h exp=%h", p, q0[p+2].row, q0[p+2].col,
                   q0[p+2].win, exp_win(p / C, p % C, 0, 20));
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int a, a6, a12;
    clear_capture();
    for (int k = 0; k < 8; k++) send_pix(8'(k + 1), (k == 0), a);
    rst      = 1'b1;
    in_data  = 8'd9;
    in_sof   = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b%b exp=00", ov0, ov1); end
    total++; if (win0 !== 72'd0 || win1 !== 72'd0) begin bad++; $display("FAIL midrst_win got=%h/%h exp=0", win0, win1); end
    total++; if (row0 !== 2'd0 || col0 !== 2'd0 || eof0 !== 1'b0 || err0 !== 1'b0)
      begin bad++; $display("FAIL midrst_fields got=r%0d c%0d eof=%b err=%b exp=0", row0, col0, eof0, err0); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", rdy0); end
    @(posedge clk);
    #1;
    clear_capture();
    send_frame(40, 1'b0, a6, a12);
    settle();
    total++; if (q0.size() != 12) begin bad++; $display("FAIL midrst_count got=%0d exp=12", q0.size()); end
    total++; if (eof_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL midrst_flags got=eof%0d err%0d exp=eof1 err0", eof_cnt, err_cnt); end
    if (q0.size() == 12) begin
      for (int p = 0; p < 12; p++) begin
        total++;
        if (q0[p].row != p / C || q0[p].col != p % C || q0[p].win !== exp_win(p / C, p % C, 0, 40)) begin
          bad++;
          $display("FAIL midrst_window p=%0d got=r%0d c%0d %h exp=%h", p, q0[p].row, q0[p].col,
                   q0[p].win, exp_win(p / C, p % C, 0, 40));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random_gaps();
    test_sof_errors();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
